// File: rtl/pll_rst_pkg.sv
// Shared types and width helpers for the PLL lock / fabric reset controller.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_lock_reset_ctrl_if.sv
// Control/status bundle between the reset controller and its fabric-side user.
interface pll_lock_reset_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             pll_lock;
    logic             sw_rst_req;
    logic             clr_cnt;
    logic             sys_reset;
    logic             ready;
    logic             loss_irq;
    logic [CNT_W-1:0] loss_cnt;

    modport master (
        output pll_lock, sw_rst_req, clr_cnt,
        input  sys_reset, ready, loss_irq, loss_cnt
    );

    modport slave (
        input  pll_lock, sw_rst_req, clr_cnt,
        output sys_reset, ready, loss_irq, loss_cnt
    );
endinterface

// File: rtl/lock_sync.sv
// Multi-flop single-bit synchroniser, cleared asynchronously by rst.
module lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/pll_lock_reset_ctrl.sv
// Qualifies PLL lock and generates the fabric system reset, with lock-loss tracking.
module pll_lock_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int CNT_W              = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_lock_reset_ctrl_if.slave  bus
);
    localparam int QW = cnt_width(LOCK_STABLE_CYCLES);
    localparam int HW = cnt_width(RESET_HOLD_CYCLES);
    localparam logic [QW-1:0]    QUAL_LAST = QW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic             lock_s;
    logic             loss_event_s;
    pll_state_e       state_q, state_d;
    logic [QW-1:0]    qual_q, qual_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             sys_reset_q, sys_reset_d;
    logic             ready_q, ready_d;
    logic             loss_irq_q, loss_irq_d;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.pll_lock),
        .q_o (lock_s)
    );

    // State and qualify/hold counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            qual_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            qual_q  <= qual_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic; entering QUALIFY already counts the first high sample.
    always_comb begin
        state_d = state_q;
        qual_d  = qual_q;
        hold_d  = hold_q;
        case (state_q)
            WAIT_LOCK: begin
                qual_d = '0;
                hold_d = '0;
                if (lock_s) begin
                    if (LOCK_STABLE_CYCLES == 1) begin
                        state_d = HOLD;
                    end else begin
                        state_d = QUALIFY;
                        qual_d  = QW'(1'b1);
                    end
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            QUALIFY: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    qual_d  = '0;
                end else if (qual_q == QUAL_LAST) begin
                    state_d = HOLD;
                    qual_d  = '0;
                    hold_d  = '0;
                end else begin
                    qual_d = qual_q + QW'(1'b1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1'b1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (bus.sw_rst_req) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                qual_d  = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Output decode from the next state so outputs move on the state edge.
    always_comb begin
        loss_event_s = (state_q == RUN) && !lock_s;
        sys_reset_d  = (state_d != RUN);
        ready_d      = (state_d == RUN);
        loss_irq_d   = loss_event_s;
        if (loss_event_s) begin
            if (bus.clr_cnt) begin
                loss_cnt_d = CNT_W'(1'b1);
            end else if (loss_cnt_q == CNT_MAX) begin
                loss_cnt_d = loss_cnt_q;
            end else begin
                loss_cnt_d = loss_cnt_q + CNT_W'(1'b1);
            end
        end else if (bus.clr_cnt) begin
            loss_cnt_d = '0;
        end else begin
            loss_cnt_d = loss_cnt_q;
        end
    end

    // Output registers; SYS_RESET is preset so it cannot glitch low during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            loss_irq_q  <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            loss_irq_q  <= loss_irq_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    assign bus.sys_reset = sys_reset_q;
    assign bus.ready     = ready_q;
    assign bus.loss_irq  = loss_irq_q;
    assign bus.loss_cnt  = loss_cnt_q;
endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Scoreboard bench for pll_lock_reset_ctrl with a short qualify/hold configuration.
module tb_pll_lock_reset_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   irq_cnt = 0;

    typedef struct {
        string tag;
        int    exp;
    } exp_t;
    exp_t sb_q[$];

    pll_lock_reset_ctrl_if #(.CNT_W(2)) bus ();

    pll_lock_reset_ctrl #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .RESET_HOLD_CYCLES  (4),
        .CNT_W              (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Count every cycle the loss interrupt is seen high.
    always @(negedge clk) begin
        if (bus.loss_irq === 1'b1) irq_cnt <= irq_cnt + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input int got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check_eq(e.tag, got, e.exp);
        end
    endtask

    // {sys_reset, ready, loss_irq, loss_cnt[1:0]}
    function automatic int obs();
        return {27'd0, bus.sys_reset, bus.ready, bus.loss_irq, bus.loss_cnt};
    endfunction

    task automatic wait_release(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.sys_reset == 1'b0) break;
        end
    endtask

    task automatic wait_assert(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.sys_reset == 1'b1) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int irq0;
        int hi;
        bus.pll_lock   = 1'b0;
        bus.sw_rst_req = 1'b0;
        bus.clr_cnt    = 1'b0;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        push_exp("reset_state", 16);
        pop_check(obs());
        rst = 1'b0;

        // Idle with no lock; stray SW_RST_REQ must be ignored.
        for (int i = 0; i < 50; i++) begin
            bus.sw_rst_req = (i >= 10 && i < 13) ? 1'b1 : 1'b0;
            push_exp("idle", 16);
            @(posedge clk);
            #1;
            pop_check(obs());
        end
        bus.sw_rst_req = 1'b0;

        // First lock-up.
        irq0 = irq_cnt;
        @(negedge clk);
        bus.pll_lock = 1'b1;
        push_exp("lock_latency", 14);
        wait_release(n);
        pop_check(n);
        push_exp("ready_run", 1);
        pop_check(int'(bus.ready));
        push_exp("irq_none_lockup", irq0);
        pop_check(irq_cnt);

        // Repeated lock losses; counter saturates at 3.
        for (int k = 0; k < 5; k++) begin
            irq0 = irq_cnt;
            @(negedge clk);
            bus.pll_lock = 1'b0;
            push_exp("loss_latency", 3);
            wait_assert(n);
            pop_check(n);
            repeat (2) @(negedge clk);
            push_exp("loss_irq_once", irq0 + 1);
            pop_check(irq_cnt);
            push_exp("loss_cnt", (k + 1 > 3) ? 3 : k + 1);
            pop_check(int'(bus.loss_cnt));
            bus.pll_lock = 1'b1;
            push_exp("relock_latency", 14);
            wait_release(n);
            pop_check(n);
        end

        // Software reset request from RUN: exactly four reset cycles.
        @(negedge clk);
        bus.sw_rst_req = 1'b1;
        @(negedge clk);
        bus.sw_rst_req = 1'b0;
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.sys_reset) hi++;
            else if (hi > 0) break;
            @(negedge clk);
        end
        push_exp("sw_hold_cycles", 4);
        pop_check(hi);
        push_exp("sw_cnt_kept", 3);
        pop_check(int'(bus.loss_cnt));
        push_exp("sw_back_run", 1);
        pop_check(int'(bus.ready));

        // Clear coinciding with a loss event gives 1.
        irq0 = irq_cnt;
        @(negedge clk);
        bus.pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        bus.clr_cnt = 1'b1;
        @(negedge clk);
        bus.clr_cnt = 1'b0;
        push_exp("clr_and_loss_cnt", 1);
        pop_check(int'(bus.loss_cnt));
        repeat (2) @(negedge clk);
        push_exp("clr_and_loss_irq", irq0 + 1);
        pop_check(irq_cnt);
        bus.pll_lock = 1'b1;
        wait_release(n);
        push_exp("relock_after_clr", 14);
        pop_check(n);

        // Clear alone.
        @(negedge clk);
        bus.clr_cnt = 1'b1;
        @(negedge clk);
        bus.clr_cnt = 1'b0;
        push_exp("clr_alone", 0);
        pop_check(int'(bus.loss_cnt));

        // One more loss, then reset asserted in RUN.
        @(negedge clk);
        bus.pll_lock = 1'b0;
        wait_assert(n);
        repeat (2) @(negedge clk);
        push_exp("cnt_before_rst", 1);
        pop_check(int'(bus.loss_cnt));
        bus.pll_lock = 1'b1;
        wait_release(n);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        push_exp("rst_in_run_async", 16);
        pop_check(obs());
        @(negedge clk);
        rst = 1'b0;
        push_exp("after_rst_run_latency", 14);
        wait_release(n);
        pop_check(n);

        // Short lock burst must not qualify.
        @(negedge clk);
        bus.pll_lock = 1'b0;
        wait_assert(n);
        repeat (3) @(negedge clk);
        irq0 = irq_cnt;
        for (int i = 0; i < 8; i++) begin
            bus.pll_lock = (i < 5) ? 1'b1 : 1'b0;
            push_exp("glitch_reset_held", 1);
            @(negedge clk);
            pop_check(int'(bus.sys_reset));
        end
        bus.pll_lock = 1'b1;
        push_exp("requalify_latency", 14);
        wait_release(n);
        pop_check(n);
        push_exp("glitch_no_irq", irq0);
        pop_check(irq_cnt);

        // Reset asserted in HOLD.
        @(negedge clk);
        bus.pll_lock = 1'b0;
        wait_assert(n);
        repeat (3) @(negedge clk);
        bus.pll_lock = 1'b1;
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        push_exp("rst_in_hold_async", 16);
        pop_check(obs());
        @(negedge clk);
        rst = 1'b0;
        push_exp("after_rst_hold_latency", 14);
        wait_release(n);
        pop_check(n);

        check_eq("sb_leftover", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
